// File: rtl/mov_xfer_if.sv
// mov_xfer_if: request, ALU writeback and debug-read signals of mov_xfer.
//   ce_n, req_valid, src_code, dst_code : move request from the MOV decoder
//   req_ready, busy, done               : move status back to the issuer
//   ext_we, ext_sel, ext_data           : ALU writeback into the register file
//   dbg_sel, dbg_data                   : asynchronous debug read
// Modports: master = request/writeback source, slave = mov_xfer.
interface mov_xfer_if #(
  parameter int DATA_W = 8
);
  logic              ce_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        src_code;
  logic [3:0]        dst_code;
  logic              ext_we;
  logic [3:0]        ext_sel;
  logic [DATA_W-1:0] ext_data;
  logic [3:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;
  logic              done;

  modport master (
    output ce_n, req_valid, src_code, dst_code, ext_we, ext_sel, ext_data, dbg_sel,
    input  req_ready, dbg_data, busy, done
  );

  modport slave (
    input  ce_n, req_valid, src_code, dst_code, ext_we, ext_sel, ext_data, dbg_sel,
    output req_ready, dbg_data, busy, done
  );
endinterface

// File: rtl/mov_xfer.sv
// mov_xfer: MOV execution stage owning the 16-entry architectural register file.
// A decoded move (src/dst code) is accepted in IDLE, the source is read into
// tmp in READ (with ALU-writeback forwarding) and written to dst in WRITE.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - mov_xfer_if.slave: request handshake, ALU writeback, debug read,
//          busy/done status
// Code 6 (INSP) resets to INSP_RESET; code 7 (FLAGS) only stores FLAGS_MASK bits.
module mov_xfer #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INSP_RESET = 8'h00,
  parameter logic [DATA_W-1:0] FLAGS_MASK = 8'h0F
) (
  input logic         clk,
  input logic         rst,
  mov_xfer_if.slave   bus
);

  localparam logic [3:0] CODE_INSP  = 4'd6;
  localparam logic [3:0] CODE_FLAGS = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        src_q;
  logic [3:0]        dst_q;
  logic [DATA_W-1:0] tmp;
  logic              done_q;
  logic [DATA_W-1:0] regs [16];

  logic accept;
  logic ext_blocked;

  function automatic logic [DATA_W-1:0] wmask(input logic [3:0] code,
                                              input logic [DATA_W-1:0] d);
    return (code == CODE_FLAGS) ? (d & FLAGS_MASK) : d;
  endfunction

  assign accept = (state == IDLE) && bus.req_valid && !bus.ce_n;

  // The move's own write has priority over an ALU writeback to the same code.
  assign ext_blocked = (state == WRITE) && (bus.ext_sel == dst_q);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      tmp    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == WRITE);
      if (accept) begin
        src_q <= bus.src_code;
        dst_q <= bus.dst_code;
      end
      if (state == READ) begin
        // Forward an ALU writeback landing on the source in this same cycle.
        if (bus.ext_we && (bus.ext_sel == src_q))
          tmp <= wmask(src_q, bus.ext_data);
        else
          tmp <= regs[src_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++)
        regs[i] <= '0;
      regs[CODE_INSP] <= INSP_RESET;
    end else begin
      if (bus.ext_we && !ext_blocked)
        regs[bus.ext_sel] <= wmask(bus.ext_sel, bus.ext_data);
      if (state == WRITE)
        regs[dst_q] <= wmask(dst_q, tmp);
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_data  = regs[bus.dbg_sel];

endmodule

// File: doc/mov_xfer.md
Name: mov_xfer

Overview:
Execution stage directly downstream of the MOV decode ROM. Accepts a decoded register-to-register move (4-bit source and destination codes plus the decoder chip-enable), then runs a two-step read/write sequence against the 16-entry architectural register file it owns. Also provides a writeback port for the ALU and an asynchronous debug read port. Register codes: 0 A, 1 X, 2 Y, 3 D, 4 DAR, 5 MBR, 6 INSP, 7 FLAGS, 8–B SA/SX/SY/SD, C–F R0–R3.

Parameters:
DATA_W, 8, register and bus width
INSP_RESET, 8'h00, reset value of INSP (code 6)
FLAGS_MASK, 8'h0F, writable bits of FLAGS (code 7); masked bits always read 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ce_n  input  1  decoder chip enable, active low; a request is accepted only when this is low
req_valid  input  1  move request valid
req_ready  output  1  high when the block can accept a request (state IDLE)
src_code  input  4  source register code (decoder src_a)
dst_code  input  4  destination register code (decoder load_addr[3:0])
ext_we  input  1  ALU writeback enable
ext_sel  input  4  ALU writeback register code
ext_data  input  DATA_W  ALU writeback data
dbg_sel  input  4  debug read select
dbg_data  output  DATA_W  combinational read of reg[dbg_sel]
busy  output  1  high in READ and WRITE
done  output  1  registered one-cycle pulse: the move has committed

Behaviour:
- One clock and a single synchronous reset. Reset is active-high.
- Reset (applies mid-operation as well):
  - state goes to IDLE and any in-flight move is dropped without a write.
  - All registers clear to 0, except INSP, which loads INSP_RESET.
  - tmp clears to 0. done and busy are 0; req_ready is 1 in the cycle after reset.
- The state machine has three states: IDLE, READ, WRITE.
- Accept condition: state IDLE, req_valid=1 and ce_n=0.
  - On accept, latch src_code and dst_code, then go to READ.
  - When req_valid=1 and ce_n=1, the request is ignored; req_ready stays 1 and no state change occurs.
- READ (1 cycle):
  - tmp <= reg[src].
  - Forwarding: if ext_we=1 and ext_sel==src in this cycle, tmp <= ext_data (masked by FLAGS_MASK when src=7).
  - Next state is WRITE.
- WRITE (1 cycle):
  - reg[dst] <= tmp; the value is masked by FLAGS_MASK when dst=7.
  - done <= 1 (visible the following cycle), then go to IDLE.
- Latency: accept on edge N, READ on N+1, WRITE on N+2, done high during N+3.
  - req_ready is high again during N+3, so back-to-back moves issue every 3 cycles.
- src == dst: the sequence runs normally and rewrites the same value; done still pulses.
- ALU writeback port:
  - ext_we writes reg[ext_sel] <= ext_data in any state, masked by FLAGS_MASK for code 7.
  - Collision in WRITE with ext_sel==dst: the move wins and the ext write is discarded.
  - Different addresses in the same cycle: both writes commit.
- dbg_data is a purely combinational read of the register array. It shows committed state only, with no forwarding.
- req_ready = (state==IDLE); busy = (state!=IDLE).
- All codes 0–F are legal; the register array has no unused entries.

Test Plan:
- Reset, then dbg_sel sweep 0–F → all read 0x00 except code 6 reading INSP_RESET. req_ready=1, done=0.
- ext_we writes A=0x5A. Move src=0 dst=1 with ce_n=0 → done pulses exactly 3 cycles after accept; dbg X=0x5A; A unchanged.
- ext write FLAGS=0xFF with FLAGS_MASK=0x0F → FLAGS reads 0x0F. Move FLAGS→R3 (7→F) → R3=0x0F.
- Move Y→D with Y=0x11, and ext_we Y=0x22 in the READ cycle → D=0x22 (forwarding). Same setup but ext_we D=0x33 in the WRITE cycle → D=0x22 (move wins).
- req_valid=1 with ce_n=1 for 5 cycles → no state change, no done, registers unchanged. Then three back-to-back valid moves → three done pulses spaced 3 cycles apart.
- Assert rst during WRITE of move 0→2 with A=0x77 → Y=0x00 after reset, no done pulse, state IDLE.
